// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings, state enum and alignment helper for mem_access_seq
package mips_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MERGE,
        ST_WR,
        ST_DONE
    } state_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - MIO bus bundle; mem_be exists only with MEM_BYTE_STROBE_EN
interface mem_access_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              MIO_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] data2cpu;
`ifdef MEM_BYTE_STROBE_EN
    logic [DATA_W/8-1:0] mem_be;

    modport master (input MIO_ready, data2cpu, output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be);
    modport slave  (output MIO_ready, data2cpu, input mem_addr, mem_rd, mem_wr, mem_wdata, mem_be);
`else
    modport master (input MIO_ready, data2cpu, output mem_addr, mem_rd, mem_wr, mem_wdata);
    modport slave  (output MIO_ready, data2cpu, input mem_addr, mem_rd, mem_wr, mem_wdata);
`endif
endinterface

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - lane extract/extend, lane insert and byte enables (be with MEM_BYTE_STROBE_EN)
module mem_lane_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  off,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] merged
`ifdef MEM_BYTE_STROBE_EN
    ,
    output logic [NB-1:0]     be
`endif
);

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top_bit;
    logic [DATA_W-1:0] shifted;

    // Right-justified bit mask covering one access of the requested size.
    always_comb begin
        case (size)
            SZ_B:    mask = DATA_W'(8'hFF);
            SZ_H:    mask = DATA_W'(16'hFFFF);
            SZ_W:    mask = DATA_W'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
    end

    // A full-width mask has an all-zero complement, so full loads never get extended.
    assign shifted  = rd_word >> {off, 3'b000};
    assign top_bit  = mask ^ (mask >> 1);
    assign load_val = (shifted & mask) | ((sign_ext && |(shifted & top_bit)) ? ~mask : '0);
    assign merged   = (base & ~(mask << {off, 3'b000})) | ((wdata & mask) << {off, 3'b000});

`ifdef MEM_BYTE_STROBE_EN
    logic [NB-1:0] be_mask;

    // One enable per byte covered by the access, before shifting into place.
    always_comb begin
        case (size)
            SZ_B:    be_mask = NB'(1);
            SZ_H:    be_mask = NB'(3);
            SZ_W:    be_mask = NB'(15);
            default: be_mask = '1;
        endcase
    end

    assign be = be_mask << off;
`endif

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle load/store sequencer (optional MEM_BYTE_STROBE_EN)
module mem_access_seq
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_cause,
    output logic [DATA_W-1:0] rdata,
    mem_access_seq_if.master  bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_t            state, state_n;
    logic              l_we, l_sext;
    logic [1:0]        l_size;
    logic [OFF_W-1:0]  l_off;
    logic [DATA_W-1:0] l_wdata, cap;
    logic [CNT_W-1:0]  cnt;
    logic              err_n;
    logic [1:0]        cause_n;
    logic              illegal, misaligned, full_w, tmo;
    logic [1:0]        ln_size;
    logic [OFF_W-1:0]  ln_off;
    logic [DATA_W-1:0] ln_wdata, ln_base, load_val, merged;
`ifdef MEM_BYTE_STROBE_EN
    logic [NB-1:0]     lane_be;
`endif

    assign illegal    = (DATA_W == 32) && (size == SZ_D);
    assign misaligned = |(addr[2:0] & align_mask(size));
    assign full_w     = (DATA_W == 64) ? (size == SZ_D) : (size == SZ_W);
    assign tmo        = (TIMEOUT != 0) && !bus.MIO_ready && (32'(cnt) == TIMEOUT - 1);

    // In IDLE the lane unit sees the live request so the first write word is ready on entry to WR.
    assign ln_size  = (state == ST_IDLE) ? size : l_size;
    assign ln_off   = (state == ST_IDLE) ? addr[OFF_W-1:0] : l_off;
    assign ln_wdata = (state == ST_IDLE) ? wdata : l_wdata;
    assign ln_base  = (state == ST_IDLE) ? '0 : cap;

    mem_lane_unit #(.DATA_W(DATA_W)) u_lane (
        .size     (ln_size),
        .off      (ln_off),
        .sign_ext (l_sext),
        .rd_word  (bus.data2cpu),
        .base     (ln_base),
        .wdata    (ln_wdata),
        .load_val (load_val),
        .merged   (merged)
`ifdef MEM_BYTE_STROBE_EN
        ,
        .be       (lane_be)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state selection and the error outcome carried into DONE.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        cause_n = CAUSE_NONE;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_n = ST_DONE;
                        err_n   = 1'b1;
                        cause_n = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_n = ST_DONE;
                        err_n   = 1'b1;
                        cause_n = CAUSE_MISALIGN;
`ifdef MEM_BYTE_STROBE_EN
                    end else if (we) begin
                        state_n = ST_WR;
`else
                    end else if (we && full_w) begin
                        state_n = ST_WR;
`endif
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (bus.MIO_ready) begin
                    state_n = l_we ? ST_MERGE : ST_DONE;
                end else if (tmo) begin
                    state_n = ST_DONE;
                    err_n   = 1'b1;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            ST_MERGE: state_n = ST_WR;
            ST_WR: begin
                if (bus.MIO_ready) begin
                    state_n = ST_DONE;
                end else if (tmo) begin
                    state_n = ST_DONE;
                    err_n   = 1'b1;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered outputs, request latches, wait counter and read/merge datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_cause     <= CAUSE_NONE;
            rdata         <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_wdata <= '0;
            cnt           <= '0;
            l_we          <= 1'b0;
            l_sext        <= 1'b0;
            l_size        <= SZ_B;
            l_off         <= '0;
            l_wdata       <= '0;
            cap           <= '0;
`ifdef MEM_BYTE_STROBE_EN
            bus.mem_be    <= '0;
`endif
        end else begin
            busy       <= (state_n != ST_IDLE);
            done       <= (state_n == ST_DONE);
            err        <= err_n;
            err_cause  <= cause_n;
            bus.mem_rd <= (state_n == ST_RD);
            bus.mem_wr <= (state_n == ST_WR);
            cnt        <= ((state == ST_RD || state == ST_WR) && state_n == state) ? cnt + 1'b1 : '0;
            if (state == ST_IDLE && req) begin
                l_we         <= we;
                l_sext       <= sign_ext;
                l_size       <= size;
                l_off        <= addr[OFF_W-1:0];
                l_wdata      <= wdata;
                bus.mem_addr <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            end
            if (state == ST_RD && bus.MIO_ready) begin
                if (l_we) cap   <= bus.data2cpu;
                else      rdata <= load_val;
            end
            if (state_n == ST_WR && state != ST_WR) bus.mem_wdata <= merged;
`ifdef MEM_BYTE_STROBE_EN
            if (state_n == ST_RD)      bus.mem_be <= '1;
            else if (state_n == ST_WR) bus.mem_be <= lane_be;
            else                       bus.mem_be <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - scoreboard bench for mem_access_seq with a behavioural memory model
module tb_mem_access_seq;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, err;
    logic [1:0]    err_cause;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    mem_access_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_access_seq #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cause (err_cause),
        .rdata     (rdata),
        .bus       (bus)
    );

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        bit          chk_rd;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          rd_wait = 0, wr_wait = 0, rd_seen = 0, wr_seen = 0, pcnt = 0;
    bit          in_phase = 0;
    logic [31:0] cur_maddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ph(input int w);
        return (w < TMO) ? w + 1 : TMO;
    endfunction

    // Reference: outcome of one access from the access rules and a word array.
    task automatic model(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input int rw, input int ww, output exp_t e);
        int     bytes, sh, idx;
        longint m, word;
        bit     rmw, upd;
        e = '{default: 0};
        bytes = 1 << sz;
        sh    = 8 * int'(a % 4);
        idx   = int'((a / 4) % 16);
        m     = (64'd1 << (8 * bytes)) - 1;
        upd   = 0;
`ifdef MEM_BYTE_STROBE_EN
        rmw = 0;
`else
        rmw = (bytes < 4);
`endif
        if (sz == 2'd3) begin
            e.err = 1; e.cause = 2'd3; e.lat = 1;
        end else if (a % bytes != 0) begin
            e.err = 1; e.cause = 2'd1; e.lat = 1;
        end else if (!w) begin
            e.nrd = ph(rw);
            e.lat = 1 + e.nrd;
            if (rw >= TMO) begin
                e.err = 1; e.cause = 2'd2;
            end else begin
                word = (longint'(ref_mem[idx]) >> sh) & m;
                if (sx && bytes < 4 && word[8 * bytes - 1]) word = word | ~m;
                e.chk_rd = 1;
                e.rdata  = word[31:0];
            end
        end else if (rmw) begin
            e.nrd = ph(rw);
            if (rw >= TMO) begin
                e.err = 1; e.cause = 2'd2; e.lat = 1 + e.nrd;
            end else begin
                e.nwr = ph(ww);
                e.lat = 2 + e.nrd + e.nwr;
                if (ww >= TMO) begin e.err = 1; e.cause = 2'd2; end
                else upd = 1;
            end
        end else begin
            e.nwr = ph(ww);
            e.lat = 1 + e.nwr;
            if (ww >= TMO) begin e.err = 1; e.cause = 2'd2; end
            else upd = 1;
        end
        if (upd) begin
            word = (longint'(ref_mem[idx]) & ~(m << sh)) | ((longint'(wd) & m) << sh);
            ref_mem[idx] = word[31:0];
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++; miscompares++;
            $display("FAIL idle_bound: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input int rw, input int ww);
        exp_t e;
        int   i;
        wait_idle();
        model(w, sz, sx, a, wd, rw, ww, e);
        rd_wait   = rw;
        wr_wait   = ww;
        cur_maddr = {a[31:2], 2'b00};
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        rd_seen = 0; wr_seen = 0;
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        for (i = 0; i < 200; i++) begin
            if (!busy) break;
            req      = done ? 1'b0 : 1'($urandom);
            we       = 1'($urandom);
            size     = 2'($urandom);
            sign_ext = 1'($urandom);
            addr     = $urandom;
            wdata    = $urandom;
            @(negedge clk);
        end
        if (i >= 200) begin
            vectors++; miscompares++;
            $display("FAIL op_bound: busy still %0b after %0d cycles", busy, i);
        end
    endtask

    function automatic int pickw();
        return ($urandom_range(0, 7) == 0) ? 4 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: ready after a per-phase wait, memory read/write on the handshake.
    always @(negedge clk) begin
        if (!reset) begin
            in_phase      = 0;
            bus.MIO_ready = 1'b0;
        end else if (bus.mem_rd || bus.mem_wr) begin
            if (!in_phase) begin
                in_phase = 1;
                pcnt     = 0;
                chk("mem_addr", bus.mem_addr, cur_maddr);
            end
            if (bus.mem_rd) rd_seen++;
            else            wr_seen++;
            if (pcnt >= (bus.mem_rd ? rd_wait : wr_wait)) begin
                bus.MIO_ready = 1'b1;
                if (bus.mem_rd) begin
                    bus.data2cpu = mem[bus.mem_addr[5:2]];
                end else begin
`ifdef MEM_BYTE_STROBE_EN
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) mem[bus.mem_addr[5:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
`else
                    mem[bus.mem_addr[5:2]] = bus.mem_wdata;
`endif
                end
            end else begin
                bus.MIO_ready = 1'b0;
                bus.data2cpu  = $urandom;
            end
            pcnt++;
        end else begin
            in_phase      = 0;
            bus.MIO_ready = 1'b0;
            bus.data2cpu  = $urandom;
        end
    end

    // Scoreboard monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_done: done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("err", err, mon_e.err);
                chk("err_cause", err_cause, mon_e.cause);
                if (mon_e.chk_rd) chk("rdata", rdata, mon_e.rdata);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
                chk("rd_cycles", rd_seen, mon_e.nrd);
                chk("wr_cycles", wr_seen, mon_e.nwr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MIO_ready = 1'b0;
        bus.data2cpu  = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cause", err_cause, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b1;
        @(negedge clk);

        mem[0] = 32'h80FF_1234; ref_mem[0] = 32'h80FF_1234;
        issue(0, 2'd0, 1, 32'h1003, 32'h0, 0, 0);
        chk("tp_signed_byte", rdata, 32'hFFFF_FF80);
        mem[0] = 32'hBEEF_0000; ref_mem[0] = 32'hBEEF_0000;
        issue(0, 2'd1, 0, 32'h2002, 32'h0, 0, 0);
        chk("tp_unsigned_half", rdata, 32'h0000_BEEF);
        mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
        issue(1, 2'd1, 0, 32'h0010, 32'h0000_AAAA, 0, 0);
        wait_idle();
        chk("tp_half_store", mem[4], 32'h1234_AAAA);
        issue(0, 2'd2, 0, 32'h0006, 32'h0, 0, 0);
        issue(0, 2'd2, 0, 32'h1008, 32'h0, 9, 0);
        issue(1, 2'd0, 0, 32'h1009, 32'h55, 9, 0);
        issue(1, 2'd2, 0, 32'h100C, 32'hDEAD_BEEF, 0, 9);
        issue(0, 2'd3, 0, 32'h1000, 32'h0, 0, 0);
        issue(0, 2'd2, 1, 32'h1004, 32'h0, 3, 0);
        issue(1, 2'd0, 0, 32'h1016, 32'hA5, 3, 3);

        wait_idle();
        rd_wait = 0; wr_wait = 1000; cur_maddr = 32'h1020;
        we = 1; size = 2'd2; sign_ext = 0; addr = 32'h1020; wdata = 32'hCAFE_F00D; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("rst_mid_wr_active", bus.mem_wr, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_mem_wr", bus.mem_wr, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        issue(0, 2'd2, 0, 32'h1020, 32'h0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 32'h1000 | ($urandom & 32'h3F);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, pickw(), pickw());
        end

        wait_idle();
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised multicycle load/store sequencer between the CPU control FSM and the MIO bus.
- Replaces the per-opcode LH/LHU/SH wait and merge states with one generic engine.
- Supports byte, half, word and double-word (DATA_W=64 only) accesses, with sign or zero extension.
- Sub-word stores use read-modify-write; includes misalignment detection and a bus wait-state timeout.

Parameters:
- DATA_W, 32, bus/register data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum cycles waiting for MIO_ready before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 dword (illegal when DATA_W=32).
- sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1=access failed.
- err_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size.
- rdata  out  DATA_W  extended load result; valid with done, held until the next done.
- MIO_ready  in  1  bus ready.
- mem_addr  out  ADDR_W  aligned address (low log2(DATA_W/8) bits zero).
- mem_rd  out  1  bus read strobe.
- mem_wr  out  1  bus write strobe.
- mem_wdata  out  DATA_W  bus write data.
- data2cpu  in  DATA_W  bus read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, err, mem_rd, mem_wr = 0.
  - err_cause=0, rdata=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE, req=1:
  - latch we, size, sign_ext, addr, wdata.
  - misaligned (half: addr[0]!=0; word: addr[1:0]!=0; dword: addr[2:0]!=0), or size=11 with DATA_W=32 → DONE with err=1 and the matching cause; no bus strobe is ever raised.
  - otherwise a load or sub-word store → RD.
  - otherwise a full-width store → WR.
- RD: mem_rd=1, mem_addr=aligned addr. On MIO_ready:
  - load → DONE; rdata = lane selected by addr low bits (little-endian), extended per sign_ext.
  - sub-word store → MERGE; the read word is captured.
- MERGE: one cycle; the wdata lane is inserted into the captured word → WR.
- WR: mem_wr=1, mem_wdata = merged or full data. On MIO_ready → DONE.
- Timeout:
  - the counter runs only in RD and WR, cleared on entry.
  - if TIMEOUT!=0 and it reaches TIMEOUT with MIO_ready still low: drop strobes next cycle, → DONE with err=1, cause=10.
  - a store that times out in RD never writes.
- DONE: done=1 for exactly one cycle → IDLE.
- Latency with MIO_ready already high:
  - load: req sampled at cycle 0, mem_rd at cycle 1, done at cycle 2.
  - full store: done at cycle 2.
  - RMW store: mem_rd at cycle 1, MERGE at cycle 2, mem_wr at cycle 3, done at cycle 4.
- req while busy is ignored. A request can be accepted again on the cycle after DONE.
- Inputs change while busy: no effect (latched at acceptance).
- Full-width loads ignore sign_ext.
- Reset mid-operation: strobes drop immediately, no done pulse, state returns to IDLE.

Optional Feature:
- Macro: MEM_BYTE_STROBE_EN.
- Defined:
  - adds output mem_be, DATA_W/8 bits, one bit per byte lane.
  - sub-word stores skip RD/MERGE and go straight to WR with mem_be marking the written lanes; RMW store latency drops to done at cycle 2.
  - loads and full stores drive mem_be all-ones; mem_be is 0 when idle.
- Not defined: mem_be does not exist; sub-word stores use RMW as above.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D).
  - err_cause codes.
  - state enum.
  - a function returning the alignment mask per size.
- One sub-module, mem_lane_unit (combinational):
  - lane extract plus sign/zero extend for loads.
  - lane insert for merges.
  - byte-enable generation.

Test Plan:
- Signed byte load: DATA_W=32, load byte, sign_ext=1, addr=0x1003, data2cpu=0x80FF_1234 with MIO_ready high → done at cycle 2, rdata=0xFFFF_FF80, err=0.
- Unsigned half load: addr=0x2002, data2cpu=0xBEEF_0000 → rdata=0x0000_BEEF.
- Half store via RMW: addr=0x10, wdata=0xAAAA, read word 0x1234_5678 → mem_wr with mem_wdata=0x1234_AAAA; done at cycle 4. With MEM_BYTE_STROBE_EN: mem_be=0011, done at cycle 2.
- Misalignment: word load at addr=0x6 → done at cycle 1, err=1, cause=01, mem_rd never asserted.
- Timeout: TIMEOUT=4, MIO_ready held low → mem_rd high for 4 cycles, then done, err=1, cause=10. A store in RD never raises mem_wr.
- Reset mid-operation: reset=0 asserted during WR → mem_wr drops asynchronously, busy=0, no done pulse; the next request completes normally.
